// File: rtl/dff_pkg.sv
// Shared constants and helpers for the dff_pipe delay-line family.
package dff_pkg;

  localparam int DFF_DEFAULT_WIDTH = 4;
  localparam int DFF_DEFAULT_DEPTH = 3;

  // Bits needed to represent values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One elastic pipeline stage: data register plus valid bit, loaded when i_en is high.
// Data only toggles when the incoming word is valid, so bubbles cost no data-path switching.
module dff_pipe_stage
  import dff_pkg::*;
#(
  parameter int              WIDTH     = DFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLR,
  input  logic             i_en,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_dat,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_dat
);

  logic             r_vld;
  logic [WIDTH-1:0] r_dat;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_vld <= 1'b0;
      r_dat <= RESET_VAL;
    end else if (CLR) begin
      r_vld <= 1'b0;
      r_dat <= RESET_VAL;
    end else if (i_en) begin
      r_vld <= i_vld;
      if (i_vld) r_dat <= i_dat;
    end
  end

  assign o_vld = r_vld;
  assign o_dat = r_dat;

endmodule

// File: rtl/dff_pipe.sv
// DEPTH-stage elastic delay line, DEPTH cycles latency, bubble-collapsing ready chain with
// pass-through ready when full. Optional per-stage even parity and PERR with DFF_PIPE_PARITY_EN.
module dff_pipe
  import dff_pkg::*;
#(
  parameter int              WIDTH     = DFF_DEFAULT_WIDTH,
  parameter int              DEPTH     = DFF_DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        CLR,
  input  logic [WIDTH-1:0]            D,
  input  logic                        D_VALID,
  output logic                        D_READY,
  output logic [WIDTH-1:0]            Q,
  output logic                        Q_VALID,
  input  logic                        Q_READY,
`ifdef DFF_PIPE_PARITY_EN
  output logic                        PERR,
`endif
  output logic [clog2(DEPTH+1)-1:0]   COUNT
);

  localparam int CW = clog2(DEPTH + 1);
`ifdef DFF_PIPE_PARITY_EN
  localparam int SW = WIDTH + 1;
  localparam logic [SW-1:0] STAGE_RST = {^RESET_VAL, RESET_VAL};
`else
  localparam int SW = WIDTH;
  localparam logic [SW-1:0] STAGE_RST = RESET_VAL;
`endif

  logic [DEPTH-1:0]         w_vld;
  logic [DEPTH-1:0]         w_rdy;
  logic [DEPTH-1:0]         w_up_vld;
  logic [DEPTH-1:0][SW-1:0] w_up_dat;
  logic [DEPTH-1:0][SW-1:0] w_sdat;
  logic [SW-1:0]            w_din;
  logic                     w_in_hs;
  logic                     w_out_hs;
  logic [CW-1:0]            r_cnt;

`ifdef DFF_PIPE_PARITY_EN
  assign w_din = {^D, D};
`else
  assign w_din = D;
`endif

  // Ready ripples from the output back: a stage can load if it is empty or its successor loads.
  always_comb begin
    w_rdy = '0;
    w_rdy[DEPTH-1] = ~w_vld[DEPTH-1] | Q_READY;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_rdy[i] = ~w_vld[i] | w_rdy[i+1];
    end
  end

  assign D_READY  = w_rdy[0] & ~CLR;
  assign w_in_hs  = D_VALID & D_READY;
  assign w_out_hs = Q_VALID & Q_READY;

  always_comb begin
    w_up_vld    = '0;
    w_up_dat    = '0;
    w_up_vld[0] = w_in_hs;
    w_up_dat[0] = w_din;
    for (int i = 1; i < DEPTH; i++) begin
      w_up_vld[i] = w_vld[i-1];
      w_up_dat[i] = w_sdat[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    dff_pipe_stage #(
      .WIDTH     (SW),
      .RESET_VAL (STAGE_RST)
    ) u_stage (
      .CLK   (CLK),
      .RST_N (RST_N),
      .CLR   (CLR),
      .i_en  (w_rdy[g]),
      .i_vld (w_up_vld[g]),
      .i_dat (w_up_dat[g]),
      .o_vld (w_vld[g]),
      .o_dat (w_sdat[g])
    );
  end

  assign Q       = w_sdat[DEPTH-1][WIDTH-1:0];
  assign Q_VALID = w_vld[DEPTH-1];

`ifdef DFF_PIPE_PARITY_EN
  assign PERR = Q_VALID & ((^Q) != w_sdat[DEPTH-1][WIDTH]);
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (CLR) begin
      r_cnt <= '0;
    end else if (w_in_hs && !w_out_hs) begin
      r_cnt <= r_cnt + CW'(1);
    end else if (!w_in_hs && w_out_hs) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign COUNT = r_cnt;

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe (WIDTH=4, DEPTH=3): stream, back-pressure, bubble collapse,
// flush, async reset and, when DFF_PIPE_PARITY_EN is defined, parity error detection.
module tb_dff_pipe;

  localparam int WIDTH = 4;
  localparam int DEPTH = 3;

  logic             CLK;
  logic             RST_N;
  logic             CLR;
  logic [WIDTH-1:0] D;
  logic             D_VALID;
  logic             D_READY;
  logic [WIDTH-1:0] Q;
  logic             Q_VALID;
  logic             Q_READY;
  logic [1:0]       COUNT;
`ifdef DFF_PIPE_PARITY_EN
  logic             PERR;
`endif

  int checks;
  int failures;

  dff_pipe #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (4'h0)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .CLR     (CLR),
    .D       (D),
    .D_VALID (D_VALID),
    .D_READY (D_READY),
    .Q       (Q),
    .Q_VALID (Q_VALID),
    .Q_READY (Q_READY),
`ifdef DFF_PIPE_PARITY_EN
    .PERR    (PERR),
`endif
    .COUNT   (COUNT)
  );

  initial CLK = 1'b0;
  always #50 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #25;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RST_N    = 1'b0;
    CLR      = 1'b0;
    D        = '0;
    D_VALID  = 1'b0;
    Q_READY  = 1'b1;

    tick();
    tick();
    check("rst_qvalid", 32'(Q_VALID), 32'd0);
    check("rst_count",  32'(COUNT),   32'd0);
    check("rst_q",      32'(Q),       32'd0);
    check("rst_dready", 32'(D_READY), 32'd1);
    RST_N = 1'b1;

    // Continuous stream of 0..15 with the consumer always ready.
    for (int i = 0; i < 19; i++) begin
      D       = 4'(i);
      D_VALID = (i < 16);
      tick();
      if (i >= 2 && i <= 17) begin
        check("stream_qvalid", 32'(Q_VALID), 32'd1);
        check("stream_q",      32'(Q),       32'(i - 2));
      end else begin
        check("stream_qvalid_idle", 32'(Q_VALID), 32'd0);
      end
      check("stream_count", 32'(COUNT),
            (i <= 15) ? ((i < 2) ? 32'(i + 1) : 32'd3) : 32'(18 - i));
    end

    // Back-pressure: fill 1,2,3 and stall the output.
    Q_READY = 1'b0;
    D_VALID = 1'b1;
    D = 4'd1; tick();
    D = 4'd2; tick();
    D = 4'd3; tick();
    D = 4'd4;
    #1;
    check("full_dready", 32'(D_READY), 32'd0);
    check("full_count",  32'(COUNT),   32'd3);
    check("full_q",      32'(Q),       32'd1);
    tick();
    check("stall_q",     32'(Q),       32'd1);
    check("stall_count", 32'(COUNT),   32'd3);
    Q_READY = 1'b1;
    #1;
    check("passthru_dready", 32'(D_READY), 32'd1);
    tick();
    Q_READY = 1'b0;
    D_VALID = 1'b0;
    check("bp_q",     32'(Q),     32'd2);
    check("bp_count", 32'(COUNT), 32'd3);
    Q_READY = 1'b1;
    tick();
    check("drain_q3",  32'(Q),     32'd3);
    check("drain_c2",  32'(COUNT), 32'd2);
    tick();
    check("drain_q4",  32'(Q),     32'd4);
    check("drain_c1",  32'(COUNT), 32'd1);
    tick();
    check("drain_qvalid", 32'(Q_VALID), 32'd0);
    check("drain_c0",     32'(COUNT),   32'd0);

    // Bubble collapse: 5, gap, 6 with output stalled.
    Q_READY = 1'b0;
    D = 4'd5; D_VALID = 1'b1; tick();
    D_VALID = 1'b0; tick();
    D = 4'd6; D_VALID = 1'b1; tick();
    D_VALID = 1'b0; tick();
    check("bub_qvalid", 32'(Q_VALID), 32'd1);
    check("bub_q",      32'(Q),       32'd5);
    check("bub_count",  32'(COUNT),   32'd2);
    check("bub_dready", 32'(D_READY), 32'd1);
    Q_READY = 1'b1;
    tick();
    check("bub_next_qvalid", 32'(Q_VALID), 32'd1);
    check("bub_next_q",      32'(Q),       32'd6);
    check("bub_next_count",  32'(COUNT),   32'd1);
    tick();
    check("bub_empty_qvalid", 32'(Q_VALID), 32'd0);

    // Flush a full pipeline while a new word is offered.
    Q_READY = 1'b0;
    D_VALID = 1'b1;
    D = 4'd7; tick();
    D = 4'd8; tick();
    D = 4'd9; tick();
    check("preflush_q",     32'(Q),     32'd7);
    check("preflush_count", 32'(COUNT), 32'd3);
    CLR     = 1'b1;
    Q_READY = 1'b1;
    D       = 4'hA;
    #1;
    check("flush_dready", 32'(D_READY), 32'd0);
    tick();
    CLR     = 1'b0;
    D_VALID = 1'b0;
    Q_READY = 1'b0;
    check("flush_qvalid", 32'(Q_VALID), 32'd0);
    check("flush_count",  32'(COUNT),   32'd0);
    check("flush_q",      32'(Q),       32'd0);
    tick();
    check("flush_noacc_count",  32'(COUNT),   32'd0);
    check("flush_noacc_qvalid", 32'(Q_VALID), 32'd0);
    check("flush_dready_back",  32'(D_READY), 32'd1);

    // Asynchronous reset between edges mid-stream.
    Q_READY = 1'b1;
    D_VALID = 1'b1;
    D = 4'hB; tick();
    D = 4'hC; tick();
    D = 4'hD; tick();
    check("prerst_qvalid", 32'(Q_VALID), 32'd1);
    check("prerst_q",      32'(Q),       32'hB);
    check("prerst_count",  32'(COUNT),   32'd3);
    RST_N = 1'b0;
    #5;
    check("arst_qvalid", 32'(Q_VALID), 32'd0);
    check("arst_count",  32'(COUNT),   32'd0);
    check("arst_q",      32'(Q),       32'd0);
    D_VALID = 1'b0;
    tick();
    RST_N = 1'b1;
    tick();

`ifdef DFF_PIPE_PARITY_EN
    // Corrupt the word sitting in the last stage and watch PERR.
    Q_READY = 1'b0;
    D = 4'd5; D_VALID = 1'b1; tick();
    D_VALID = 1'b0; tick();
    tick();
    check("par_q",       32'(Q),    32'd5);
    check("par_ok_perr", 32'(PERR), 32'd0);
    force dut.g_stage[2].u_stage.r_dat = 5'b0_0100;
    #1;
    check("par_err_perr", 32'(PERR), 32'd1);
    release dut.g_stage[2].u_stage.r_dat;
    tick();
    check("par_err_hold", 32'(PERR), 32'd1);
    Q_READY = 1'b1;
    tick();
    check("par_clear_qvalid", 32'(Q_VALID), 32'd0);
    check("par_clear_perr",   32'(PERR),    32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dff_pipe.md
Name: dff_pipe

Overview:
Parametrised successor to the team's plain WIDTH-bit D flip-flop. It is a DEPTH-stage elastic register pipeline with valid/ready handshake on both sides and per-stage valid tracking. Stalls collapse bubbles, and it supports a synchronous flush and an occupancy count. It is used wherever a datapath needs a fixed-latency, back-pressurable delay line.

Parameters:
WIDTH, 4, data width in bits (>=1)
DEPTH, 3, number of register stages (>=1)
RESET_VAL, 0, value loaded into every data stage on reset/flush (WIDTH bits)

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
CLR  input  1  synchronous flush, active-high
D  input  WIDTH  input data
D_VALID  input  1  D is valid this cycle
D_READY  output  1  pipeline accepts D this cycle
Q  output  WIDTH  data of last stage (stage DEPTH-1)
Q_VALID  output  1  last stage holds valid data
Q_READY  input  1  consumer accepts Q this cycle
COUNT  output  clog2(DEPTH+1)  number of valid stages

Behaviour:
- Reset (RST_N=0, asynchronous): all stage valids=0, all data=RESET_VAL, Q=RESET_VAL, Q_VALID=0, COUNT=0. Takes effect immediately, mid-transfer included; in-flight data is discarded.
- Stage i has reg data[i] and valid v[i]. Stage 0 loads from D. Stage i loads from stage i-1. Q=data[DEPTH-1], Q_VALID=v[DEPTH-1].
- Ready chain (combinational): rdy[DEPTH-1] = ~v[DEPTH-1] | Q_READY. rdy[i] = ~v[i] | rdy[i+1]. D_READY = rdy[0] & ~CLR.
- Stage i captures on the edge when rdy[i]=1. v[i] takes the upstream valid (D_VALID&D_READY for stage 0). data[i] updates only if the upstream valid=1; otherwise data holds, for power.
- Input handshake is D_VALID&D_READY. Output handshake is Q_VALID&Q_READY. While Q_VALID=1 and Q_READY=0, Q is stable.
- Latency: a word accepted at edge k is presented on Q after edge k+DEPTH-1, i.e. DEPTH register stages.
- Throughput: one word per cycle when Q_READY is held high.
- Bubble collapse: with output stalled, an empty intermediate stage still accepts upstream data.
- Full: all v=1 and Q_READY=0 gives D_READY=0. Q_READY=1 in the full state gives D_READY=1 in the same cycle (pass-through ready).
- CLR=1: at the next edge all v=0, data=RESET_VAL, COUNT=0. CLR overrides a simultaneous accept, and D_READY=0 while CLR=1. An output handshake in the CLR cycle still counts as delivered.
- COUNT: registered. +1 on input handshake only, -1 on output handshake only, unchanged on both or neither. Never exceeds DEPTH and never underflows.
- No wrap-around: data order is strictly FIFO and no stage is overwritten while valid and stalled.

Optional Feature:
DFF_PIPE_PARITY_EN
- Defined: each stage stores an extra even-parity bit computed from D at stage 0. Adds output PERR (1 bit) = Q_VALID & (^Q != stored parity). PERR resets to 0.
- Undefined: no parity storage and no PERR port. Behaviour is otherwise identical.

Decomposition:
- Shared package/header dff_pkg: clog2 function, DFF_DEFAULT_WIDTH=4, DFF_DEFAULT_DEPTH=3.
- Sub-module dff_pipe_stage: one WIDTH-bit data reg plus valid bit. It has async RST_N, sync CLR, and load-enable. dff_pipe instantiates DEPTH of these in a generate loop and builds the ready chain.

Test Plan (WIDTH=4, DEPTH=3, CYCLE=100, stimulus a quarter cycle after edges):
- Reset then stream: RST_N low 2 cycles, then D=0..15 with D_VALID=1 and Q_READY=1. Required: Q_VALID rises 3 edges after first accept, Q=0,1,...,15 in order, one per cycle, COUNT settles at 3.
- Back-pressure: fill with 1,2,3 and hold Q_READY=0. Required: D_READY=0, COUNT=3, Q=1 stable. Raise Q_READY for 1 cycle with D=4: Q becomes 2 and COUNT stays 3.
- Bubble collapse: send 5 then idle one cycle then 6, with Q_READY=0. Required: both words packed into stages 2 and 1, COUNT=2, D_READY=1.
- Flush: pipeline holding 7,8,9 with CLR=1 and D_VALID=1 for 1 cycle. Required: next edge Q_VALID=0, COUNT=0, Q=RESET_VAL, and D was not accepted.
- Async reset mid-stream: drop RST_N between edges during the streaming test. Required: Q_VALID=0 and COUNT=0 immediately, no edge needed.
- With DFF_PIPE_PARITY_EN: force a bit flip in stage 2 data via the bench. Required: PERR=1 while that word is on Q, and 0 otherwise.
